// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : EX pipeline stage. Single-cycle ALU operations, a DATA_WIDTH-step
//            iterative shift-add multiply, NZCV flag generation, branch
//            resolution and an output holding register behind a valid/ready
//            handshake on both sides.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, resetN          clock (rising edge), async active-low reset
//   inValid / inReady      upstream handshake (inReady is combinational)
//   aluOp                  operation select
//   readData1, readData2   operands A and B
//   pcIn, pcOffsetFilled   branch target inputs
//   branchFlag, branchNotZero, uncondBranchFlag, setFlags   decode control
//   regWriteIn, memReadFlag, memWriteFlag, writeRegIn       forwarded control
//   outValid / outReady    downstream handshake
//   aluResult, zeroFlag, branchTaken, branchTarget, storeData  results
//   regWriteOut, memReadOut, memWriteOut, writeRegOut       forwarded control
//   flags                  architectural NZCV (bit 3 = N)
// ============================================================================
module execute_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_SHIFT = 2
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [3:0]            aluOp,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic [DATA_WIDTH-1:0] pcIn,
    input  logic [DATA_WIDTH-1:0] pcOffsetFilled,
    input  logic                  branchFlag,
    input  logic                  branchNotZero,
    input  logic                  uncondBranchFlag,
    input  logic                  setFlags,
    input  logic                  regWriteIn,
    input  logic                  memReadFlag,
    input  logic                  memWriteFlag,
    input  logic [4:0]            writeRegIn,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] aluResult,
    output logic                  zeroFlag,
    output logic                  branchTaken,
    output logic [DATA_WIDTH-1:0] branchTarget,
    output logic [DATA_WIDTH-1:0] storeData,
    output logic                  regWriteOut,
    output logic                  memReadOut,
    output logic                  memWriteOut,
    output logic [4:0]            writeRegOut,
    output logic [3:0]            flags
);

    localparam int         CNT_W    = $clog2(DATA_WIDTH);
    localparam int         MSB      = DATA_WIDTH - 1;
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_ORR = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_PSB = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_LSL = 4'b1000;
    localparam logic [3:0] c_OP_LSR = 4'b1001;
    localparam logic [3:0] c_OP_MUL = 4'b1010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_mulA;
    logic [DATA_WIDTH-1:0] r_mulB;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_bf;
    logic                  r_bnz;
    logic                  r_ub;

    logic                  w_accept;
    logic                  w_isMul;
    logic                  w_mulDone;
    logic [DATA_WIDTH-1:0] w_mulSum;
    logic [DATA_WIDTH-1:0] w_res;
    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_c;
    logic                  w_v;
    logic                  w_flagUpd;
    logic                  w_resZero;
    logic                  w_mulZero;

    assign inReady   = (r_state == ST_IDLE) && (!outValid || outReady);
    assign w_accept  = inValid && inReady;
    assign w_isMul   = (aluOp == c_OP_MUL);
    assign w_mulDone = (r_state == ST_MUL) && (r_cnt == CNT_W'(DATA_WIDTH - 1));
    // One shift-add step per cycle on bit r_cnt of B; only the low word is kept.
    assign w_mulSum  = r_acc + (r_mulB[r_cnt] ? (r_mulA << r_cnt) : '0);
    assign w_resZero = (w_res == '0);
    assign w_mulZero = (w_mulSum == '0);

    // Single-cycle ALU and flag generation
    always_comb begin
        w_res     = '0;
        w_sum     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_flagUpd = 1'b0;
        case (aluOp)
            c_OP_AND: w_res = readData1 & readData2;
            c_OP_ORR: w_res = readData1 | readData2;
            c_OP_ADD: begin
                w_sum     = {1'b0, readData1} + {1'b0, readData2};
                w_res     = w_sum[MSB:0];
                w_c       = w_sum[DATA_WIDTH];
                w_v       = (readData1[MSB] == readData2[MSB]) && (w_res[MSB] != readData1[MSB]);
                w_flagUpd = setFlags;
            end
            c_OP_SUB: begin
                // Top bit of the widened difference is the borrow; C is its inverse.
                w_sum     = {1'b0, readData1} - {1'b0, readData2};
                w_res     = w_sum[MSB:0];
                w_c       = ~w_sum[DATA_WIDTH];
                w_v       = (readData1[MSB] != readData2[MSB]) && (w_res[MSB] != readData1[MSB]);
                w_flagUpd = setFlags;
            end
            c_OP_PSB: w_res = readData2;
            c_OP_NOR: w_res = ~(readData1 | readData2);
            c_OP_LSL: w_res = readData1 << readData2[CNT_W-1:0];
            c_OP_LSR: w_res = readData1 >> readData2[CNT_W-1:0];
            default:  w_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next state
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_isMul) w_stateNext = ST_MUL;
            ST_MUL:  if (w_mulDone)           w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Multiply datapath; branch controls are kept so the result can be resolved at completion.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_cnt  <= '0;
            r_mulA <= '0;
            r_mulB <= '0;
            r_acc  <= '0;
            r_bf   <= 1'b0;
            r_bnz  <= 1'b0;
            r_ub   <= 1'b0;
        end else if (w_accept && w_isMul) begin
            r_cnt  <= '0;
            r_mulA <= readData1;
            r_mulB <= readData2;
            r_acc  <= '0;
            r_bf   <= branchFlag;
            r_bnz  <= branchNotZero;
            r_ub   <= uncondBranchFlag;
        end else if (r_state == ST_MUL) begin
            r_acc <= w_mulSum;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Output holding register. Forwarded fields load on every accept; during a
    // multiply outValid is low so their early update is not observable as a result.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            outValid     <= 1'b0;
            aluResult    <= '0;
            zeroFlag     <= 1'b0;
            branchTaken  <= 1'b0;
            branchTarget <= '0;
            storeData    <= '0;
            regWriteOut  <= 1'b0;
            memReadOut   <= 1'b0;
            memWriteOut  <= 1'b0;
            writeRegOut  <= '0;
            flags        <= 4'b0000;
        end else begin
            if (w_accept) begin
                outValid     <= !w_isMul;
                branchTarget <= pcIn + (pcOffsetFilled << OFFSET_SHIFT);
                storeData    <= readData2;
                regWriteOut  <= regWriteIn;
                memReadOut   <= memReadFlag;
                memWriteOut  <= memWriteFlag;
                writeRegOut  <= writeRegIn;
                if (!w_isMul) begin
                    aluResult   <= w_res;
                    zeroFlag    <= w_resZero;
                    branchTaken <= uncondBranchFlag | (branchFlag & (w_resZero ^ branchNotZero));
                    if (w_flagUpd) begin
                        flags <= {w_res[MSB], w_resZero, w_c, w_v};
                    end
                end
            end else if (w_mulDone) begin
                outValid    <= 1'b1;
                aluResult   <= w_mulSum;
                zeroFlag    <= w_mulZero;
                branchTaken <= r_ub | (r_bf & (w_mulZero ^ r_bnz));
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Self-checking bench for execute_stage. A transaction-level model
//            (result queue plus multiply countdown) predicts every output each
//            cycle; directed scenarios pin the model with literal values, then
//            randomized traffic with random back-pressure follows.
// Revision : 1.0  initial release
// ============================================================================
module tb_execute_stage;

    localparam logic [3:0] AND_ = 4'b0000, ORR_ = 4'b0001, ADD_ = 4'b0010, SUB_ = 4'b0110;
    localparam logic [3:0] PSB_ = 4'b0111, NOR_ = 4'b1100, LSL_ = 4'b1000, LSR_ = 4'b1001;
    localparam logic [3:0] MUL_ = 4'b1010;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        inValid = 1'b0, inReady;
    logic [3:0]  aluOp = 4'b0;
    logic [31:0] readData1 = '0, readData2 = '0, pcIn = '0, pcOffsetFilled = '0;
    logic        branchFlag = 1'b0, branchNotZero = 1'b0, uncondBranchFlag = 1'b0, setFlags = 1'b0;
    logic        regWriteIn = 1'b0, memReadFlag = 1'b0, memWriteFlag = 1'b0;
    logic [4:0]  writeRegIn = '0;
    logic        outValid, outReady = 1'b1;
    logic [31:0] aluResult, branchTarget, storeData;
    logic        zeroFlag, branchTaken, regWriteOut, memReadOut, memWriteOut;
    logic [4:0]  writeRegOut;
    logic [3:0]  flags;

    always #5 clock = ~clock;

    execute_stage #(.DATA_WIDTH(32), .OFFSET_SHIFT(2)) dut (
        .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .aluOp(aluOp), .readData1(readData1), .readData2(readData2), .pcIn(pcIn),
        .pcOffsetFilled(pcOffsetFilled), .branchFlag(branchFlag), .branchNotZero(branchNotZero),
        .uncondBranchFlag(uncondBranchFlag), .setFlags(setFlags), .regWriteIn(regWriteIn),
        .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag), .writeRegIn(writeRegIn),
        .outValid(outValid), .outReady(outReady), .aluResult(aluResult), .zeroFlag(zeroFlag),
        .branchTaken(branchTaken), .branchTarget(branchTarget), .storeData(storeData),
        .regWriteOut(regWriteOut), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
        .writeRegOut(writeRegOut), .flags(flags)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        bt;
        logic [31:0] tgt;
        logic [31:0] sd;
        logic        rw, mr, mw;
        logic [4:0]  wr;
    } exp_t;

    exp_t       q[$];
    exp_t       mul_e;
    int         mul_left = 0;
    bit         mul_pending = 0;
    logic [3:0] mflags = 4'b0;
    int         checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        case (op)
            AND_: return a & b;
            ORR_: return a | b;
            ADD_: return a + b;
            SUB_: return a - b;
            PSB_: return b;
            NOR_: return ~(a | b);
            LSL_: return a << b[4:0];
            LSR_: return a >> b[4:0];
            MUL_: begin p = 64'(a) * 64'(b); return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    // NZCV from exact integer arithmetic
    function automatic logic [3:0] flags_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        logic [31:0] r;
        logic c, v;
        r = alu_ref(op, a, b);
        if (op == ADD_) begin
            s = longint'($signed(a)) + longint'($signed(b));
            c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        end else begin
            s = longint'($signed(a)) - longint'($signed(b));
            c = (a >= b);
        end
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {r[31], (r == 32'h0), c, v};
    endfunction

    // Model and per-cycle comparison; the handshake decisions made here take effect at the next edge.
    always @(negedge clock) begin : compare
        bit   exp_rdy, pop, acc;
        exp_t e;
        if (!resetN) begin
            q.delete();
            mul_pending = 0;
            mul_left    = 0;
            mflags      = 4'b0;
        end else begin
            chk("outValid", outValid, q.size() != 0);
            if (q.size() != 0 && outValid) begin
                chk("aluResult",    aluResult,    q[0].res);
                chk("zeroFlag",     zeroFlag,     q[0].zero);
                chk("branchTaken",  branchTaken,  q[0].bt);
                chk("branchTarget", branchTarget, q[0].tgt);
                chk("storeData",    storeData,    q[0].sd);
                chk("ctrl",         {regWriteOut, memReadOut, memWriteOut, writeRegOut},
                                    {q[0].rw, q[0].mr, q[0].mw, q[0].wr});
            end
            chk("flags", flags, mflags);
            exp_rdy = !mul_pending && (q.size() == 0 || outReady);
            chk("inReady", inReady, exp_rdy);
            pop = (q.size() != 0) && outReady;
            acc = inValid && exp_rdy;
            if (pop) void'(q.pop_front());
            if (mul_pending) begin
                mul_left--;
                if (mul_left == 0) begin
                    q.push_back(mul_e);
                    mul_pending = 0;
                end
            end
            if (acc) begin
                e.res  = alu_ref(aluOp, readData1, readData2);
                e.zero = (e.res == 32'h0);
                e.bt   = uncondBranchFlag | (branchFlag & (e.zero ^ branchNotZero));
                e.tgt  = pcIn + pcOffsetFilled * 4;
                e.sd   = readData2;
                e.rw   = regWriteIn;
                e.mr   = memReadFlag;
                e.mw   = memWriteFlag;
                e.wr   = writeRegIn;
                if (aluOp == MUL_) begin
                    mul_e       = e;
                    mul_pending = 1;
                    mul_left    = 32;
                end else begin
                    q.push_back(e);
                    if (setFlags && (aluOp == ADD_ || aluOp == SUB_))
                        mflags = flags_ref(aluOp, readData1, readData2);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off,
                         input logic bf, input logic bnz, input logic ub, input logic sf);
        aluOp = op; readData1 = a; readData2 = b; pcIn = pc; pcOffsetFilled = off;
        branchFlag = bf; branchNotZero = bnz; uncondBranchFlag = ub; setFlags = sf;
        regWriteIn = 1'($urandom); memReadFlag = 1'($urandom); memWriteFlag = 1'($urandom);
        writeRegIn = 5'($urandom);
    endtask

    // Present an op and hold it until it is accepted (bounded)
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off,
                         input logic bf, input logic bnz, input logic ub, input logic sf);
        @(posedge clock); #1;
        drive(op, a, b, pc, off, bf, bnz, ub, sf);
        inValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (inReady) begin
                @(posedge clock); #1;
                inValid = 1'b0;
                return;
            end
        end
        inValid = 1'b0;
        chk("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (outValid) return;
        end
        chk("wait_out_timeout", 32'd1, 32'd0);
    endtask

    logic [3:0]  ops [12] = '{AND_, ORR_, ADD_, SUB_, PSB_, NOR_, LSL_, LSR_, MUL_, ADD_, SUB_, 4'b0011};
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_001F};

    function automatic logic [31:0] rnd_operand();
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin : stim
        int busy;
        logic [31:0] a, b;
        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_outValid",  outValid,     32'd0);
        chk("rst_flags",     flags,        32'd0);
        chk("rst_aluResult", aluResult,    32'd0);
        chk("rst_target",    branchTarget, 32'd0);
        chk("rst_inReady",   inReady,      32'd1);

        // ADDS signed overflow
        outReady = 1'b1;
        issue(ADD_, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 0, 0, 0, 1);
        wait_out();
        chk("adds_res",   aluResult, 32'h8000_0000);
        chk("adds_flags", flags,     32'b1001);

        // SUBS equal operands with CBZ then CBNZ
        issue(SUB_, 32'd5, 32'd5, 32'h0, 32'h0, 1, 0, 0, 1);
        wait_out();
        chk("subs_res",   aluResult,   32'h0);
        chk("subs_zero",  zeroFlag,    32'd1);
        chk("subs_flags", flags,       32'b0110);
        chk("cbz_taken",  branchTaken, 32'd1);
        issue(SUB_, 32'd5, 32'd5, 32'h0, 32'h0, 1, 1, 0, 1);
        wait_out();
        chk("cbnz_taken", branchTaken, 32'd0);

        // Iterative multiply
        issue(MUL_, 32'h0001_0003, 32'h0002_0005, 32'h0, 32'h0, 0, 0, 0, 0);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (outValid) break;
            if (!inReady) busy++;
        end
        chk("mul_busy_cycles", busy,      32'd32);
        chk("mul_res",         aluResult, 32'h000B_000F);
        chk("mul_flags",       flags,     32'b0110);

        // Back-pressure with a queued ORR released on the same edge
        issue(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 0, 0, 0, 0);
        outReady = 1'b0;
        drive(ORR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 0, 0, 0, 0);
        inValid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("bp_hold_res", aluResult, 32'hF000_F000);
            chk("bp_inReady",  inReady,   32'd0);
        end
        @(posedge clock); #1 outReady = 1'b1;
        @(posedge clock); #1 inValid = 1'b0;
        @(negedge clock);
        chk("bp_orr_res",   aluResult, 32'hFFF0_FFF0);
        chk("bp_orr_valid", outValid,  32'd1);

        // Unconditional branch with negative offset
        issue(PSB_, 32'h0, 32'h0, 32'h100, 32'hFFFF_FFFE, 0, 0, 1, 0);
        wait_out();
        chk("b_taken",  branchTaken,  32'd1);
        chk("b_target", branchTarget, 32'h0000_00F8);

        // Reset in the middle of a multiply
        issue(MUL_, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 0, 0, 0, 0);
        repeat (9) @(posedge clock);
        #1 resetN = 1'b0;
        @(negedge clock);
        chk("mrst_outValid", outValid, 32'd0);
        chk("mrst_flags",    flags,    32'd0);
        @(posedge clock); #1 resetN = 1'b1;
        @(negedge clock);
        chk("mrst_inReady", inReady, 32'd1);
        repeat (40) @(negedge clock);
        chk("mrst_no_valid", outValid, 32'd0);

        // Randomized traffic with random back-pressure
        for (int n = 0; n < 3000; n++) begin
            @(posedge clock); #1;
            a = rnd_operand();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_operand();
            drive(ops[$urandom_range(0, 11)], a, b, $urandom, rnd_operand(),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock); #1 inValid = 1'b0; outReady = 1'b1;
        repeat (40) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage directly downstream of the operand-prep/register-file stage.
- Consumes readData1, readData2 and pcOffsetFilled, plus control bits forwarded from decode.
- Produces the ALU result, the NZCV flags, and branch resolution (taken/target) for the memory/writeback path.
- Single-cycle ALU ops, a 32-cycle iterative multiply, and a valid/ready handshake on both sides with an output holding register.

Parameters:
- DATA_WIDTH, 32, operand/result width; MUL iteration count equals DATA_WIDTH.
- OFFSET_SHIFT, 2, left shift applied to pcOffsetFilled when forming the branch target (word-addressed offsets).

Ports:
- clock  in  1  main clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- inValid  in  1  upstream presents a valid operation.
- inReady  out  1  stage accepts an operation this cycle.
- aluOp  in  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASSB, 1100 NOR, 1000 LSL, 1001 LSR, 1010 MUL.
- readData1  in  32  operand A.
- readData2  in  32  operand B (register or immediate).
- pcIn  in  32  PC of this instruction.
- pcOffsetFilled  in  32  sign-extended branch offset.
- branchFlag  in  1  conditional branch: CBZ, or CBNZ with branchNotZero.
- branchNotZero  in  1  invert the zero test (CBNZ).
- uncondBranchFlag  in  1  unconditional B.
- setFlags  in  1  update NZCV (ADDS/SUBS).
- regWriteIn, memReadFlag, memWriteFlag  in  1 each  forwarded control.
- writeRegIn  in  5  destination register.
- outValid  out  1  result valid.
- outReady  in  1  downstream accepts the result.
- aluResult  out  32  result.
- zeroFlag  out  1  aluResult == 0.
- branchTaken  out  1  branch resolved taken.
- branchTarget  out  32  pcIn + (pcOffsetFilled << OFFSET_SHIFT), modulo 2^32.
- storeData  out  32  readData2 captured at accept.
- regWriteOut, memReadOut, memWriteOut  out  1 each  forwarded control.
- writeRegOut  out  5  forwarded destination register.
- flags  out  4  NZCV architectural flags, bit 3 = N.

Behaviour:
- Reset (async, resetN = 0): state IDLE, outValid = 0, flags = 0000, all data and control outputs = 0, multiply counter = 0.
- States:
  - IDLE: no multiply in flight.
  - MUL: iterating.
- Accept condition: inValid && inReady.
- inReady = (state == IDLE) && (!outValid || outReady). It is combinational and is 0 throughout MUL.
- Non-MUL accept:
  - The next rising edge loads aluResult, zeroFlag, branch outputs and forwarded fields, and sets outValid = 1.
  - Latency is 1 cycle. Back-to-back accepts give full throughput while outReady = 1.
- MUL accept:
  - Latch the operands, go to MUL, counter = 0.
  - Each cycle do one shift-add step on bit [counter] of B.
  - At counter == 31, register the low 32 bits of the product, set outValid = 1 and return to IDLE.
  - outValid rises 32 cycles after the accept edge.
- Holding: while outValid && !outReady, every output is held stable. outValid drops on the edge where outReady = 1, unless a new op is accepted on that same edge.
- Arithmetic:
  - ADD and SUB wrap modulo 2^32.
  - LSL/LSR shift by readData2[4:0]; LSR is logical.
  - PASSB gives readData2.
  - NOR gives ~(A | B).
- Flags:
  - Updated only when setFlags && aluOp is ADD or SUB, on the edge that loads the result.
  - N = result[31]; Z = result == 0.
  - ADD: C = carry out of bit 31.
  - SUB: C = 1 when A >= B unsigned (no borrow).
  - V = signed overflow.
  - Otherwise flags are held.
- Branch:
  - branchTaken = uncondBranchFlag | (branchFlag & (zeroFlag ^ branchNotZero)).
  - branchTarget is always computed; it is meaningful only when branchTaken = 1.
- Undefined aluOp: aluResult = 0, zeroFlag = 1, flags unchanged, forwarded control still passes.
- Reset asserted mid-MUL: the operation is discarded, state returns to IDLE and no outValid is produced.
- inValid while inReady = 0: the operation is not captured; upstream must hold it.

Test Plan:
- Reset then ADD with setFlags, A = 0x7FFFFFFF, B = 1 → next cycle aluResult = 0x80000000, flags N = 1, Z = 0, C = 0, V = 1, outValid = 1.
- SUB with setFlags, A = 5, B = 5, branchFlag = 1 → aluResult = 0, zeroFlag = 1, flags = 0110 (Z, C), branchTaken = 1. Repeat with branchNotZero = 1 → branchTaken = 0.
- MUL, A = 0x00010003, B = 0x00020005 → inReady = 0 for 32 cycles, then aluResult = 0x000B000F (low 32 bits), flags unchanged.
- Back-pressure: outReady = 0 for 3 cycles after an AND of 0xF0F0F0F0 and 0xFF00FF00 → outputs stay 0xF000F000 and inReady = 0. Releasing outReady = 1 together with a queued ORR accepts that ORR on the same edge.
- B with pcIn = 0x100, pcOffsetFilled = 0xFFFFFFFE, uncondBranchFlag = 1 → branchTaken = 1, branchTarget = 0x000000F8.
- Assert resetN = 0 at cycle 10 of a MUL → outValid stays 0, inReady = 1 after release, flags = 0000.
